// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the L1 dcache tag array.
package dcache_pkg;

  localparam int unsigned TAG_ARRAY_IDX_HIGH = 11;
  localparam int unsigned TAG_ARRAY_IDX_LOW  = 6;
  localparam int unsigned WAYS               = 4;
  localparam int unsigned TAG_WIDTH          = 20;
  localparam int unsigned IDX_W              = TAG_ARRAY_IDX_HIGH - TAG_ARRAY_IDX_LOW + 1;
  localparam int unsigned SETS               = 1 << IDX_W;

  // One way's worth of tag state.
  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
  } tag_way_t;

  // StInit: clearing sweep in progress, StIdle: serving reads and writes.
  typedef enum logic {
    StInit = 1'b0,
    StIdle = 1'b1
  } state_e;

endpackage

// File: rtl/dcache_tag_sram.sv
// Generic 1R1W storage: per-way write enables, one-cycle registered read, no reset.
module dcache_tag_sram #(
  parameter int unsigned NumWays   = 4,
  parameter int unsigned DataWidth = 20,
  parameter int unsigned AddrWidth = 6,
  localparam int unsigned Depth    = 1 << AddrWidth
) (
  input  logic                           clock,
  input  logic [NumWays-1:0]             wr_en,
  input  logic [AddrWidth-1:0]           wr_addr,
  input  logic [NumWays*DataWidth-1:0]   wr_data,
  input  logic                           rd_en,
  input  logic [AddrWidth-1:0]           rd_addr,
  output logic [NumWays*DataWidth-1:0]   rd_data
);

  logic [NumWays*DataWidth-1:0] mem_q [Depth];
  logic [NumWays*DataWidth-1:0] rd_data_q;

  // Array write per selected way; the read captures pre-write contents on a collision.
  always_ff @(posedge clock) begin
    for (int w = 0; w < NumWays; w++) begin
      if (wr_en[w]) begin
        mem_q[wr_addr][w*DataWidth +: DataWidth] <= wr_data[w*DataWidth +: DataWidth];
      end
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dcache_tagarray.sv
// L1 dcache tag/valid array: stage-1 tag read responder, single-way writes and
// a self-clearing init sweep that blocks readers and writers while it runs.
module dcache_tagarray #(
  parameter int unsigned TAG_ARRAY_IDX_HIGH = dcache_pkg::TAG_ARRAY_IDX_HIGH,
  parameter int unsigned TAG_ARRAY_IDX_LOW  = dcache_pkg::TAG_ARRAY_IDX_LOW,
  parameter int unsigned WAYS               = dcache_pkg::WAYS,
  parameter int unsigned TAG_WIDTH          = dcache_pkg::TAG_WIDTH,
  localparam int unsigned IDX_W             = TAG_ARRAY_IDX_HIGH - TAG_ARRAY_IDX_LOW + 1,
  localparam int unsigned SETS              = 1 << IDX_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      tagarray_rd_en,
  input  logic [IDX_W-1:0]          tagarray_rd_idx,
  output logic                      tagarray_rd_ready,
  output logic                      tagarray_rd_resp_valid,
  output logic [WAYS*TAG_WIDTH-1:0] tagarray_rd_tags,
  output logic [WAYS-1:0]           tagarray_rd_valids,
  input  logic                      tagarray_wr_en,
  input  logic [IDX_W-1:0]          tagarray_wr_idx,
  input  logic [WAYS-1:0]           tagarray_wr_way,
  input  logic [TAG_WIDTH-1:0]      tagarray_wr_tag,
  input  logic                      tagarray_wr_valid,
  output logic                      tagarray_wr_ready,
  input  logic                      inv_all_req,
  output logic                      init_busy
);

  import dcache_pkg::*;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic                      sweep;
  logic                      rd_fire, wr_fire;

  logic [WAYS-1:0]           valid_q [SETS];
  logic [WAYS-1:0]           wr_valid_merge;
  logic [WAYS-1:0]           byp_mask_d;
  logic [WAYS-1:0]           rd_valids_next;

  logic [WAYS-1:0]           sram_wr_en;
  logic [IDX_W-1:0]          sram_wr_addr;
  logic [WAYS*TAG_WIDTH-1:0] sram_wr_data;
  logic [WAYS*TAG_WIDTH-1:0] sram_rd_data;

  logic                      resp_valid_q;
  logic [WAYS-1:0]           rd_valids_q;
  logic [WAYS-1:0]           byp_mask_q;
  logic [TAG_WIDTH-1:0]      byp_tag_q;
  logic [WAYS*TAG_WIDTH-1:0] hold_tags_q;
  logic [WAYS*TAG_WIDTH-1:0] merged_tags;

  assign sweep             = (state_q == StInit);
  assign init_busy         = sweep;
  assign tagarray_rd_ready = ~sweep;
  assign tagarray_wr_ready = ~sweep;
  assign rd_fire           = tagarray_rd_en & ~sweep;
  assign wr_fire           = tagarray_wr_en & ~sweep;

  // Next-state logic: sweep one set per cycle, leave after the last set is cleared.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (inv_all_req) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  // State and sweep counter; reset restarts the sweep from set 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Valid-bit merge for a write and write-first view of the set being read.
  always_comb begin
    wr_valid_merge = (valid_q[tagarray_wr_idx] & ~tagarray_wr_way) |
                     ({WAYS{tagarray_wr_valid}} & tagarray_wr_way);
    byp_mask_d     = '0;
    if (wr_fire && (tagarray_wr_idx == tagarray_rd_idx)) begin
      byp_mask_d = tagarray_wr_way;
    end
    rd_valids_next = (valid_q[tagarray_rd_idx] & ~byp_mask_d) |
                     ({WAYS{tagarray_wr_valid}} & byp_mask_d);
  end

  // Valid storage: cleared only by the sweep, so it carries no reset.
  always_ff @(posedge clock) begin
    if (sweep) begin
      valid_q[cnt_q] <= '0;
    end else if (wr_fire) begin
      valid_q[tagarray_wr_idx] <= wr_valid_merge;
    end
  end

  // Tag storage port muxing: the sweep owns the write port while it runs.
  always_comb begin
    sram_wr_en   = '0;
    sram_wr_addr = tagarray_wr_idx;
    sram_wr_data = {WAYS{tagarray_wr_tag}};
    if (sweep) begin
      sram_wr_en   = '1;
      sram_wr_addr = cnt_q;
      sram_wr_data = '0;
    end else if (wr_fire) begin
      sram_wr_en   = tagarray_wr_way;
    end
  end

  dcache_tag_sram #(
    .NumWays   (WAYS),
    .DataWidth (TAG_WIDTH),
    .AddrWidth (IDX_W)
  ) u_tag_sram (
    .clock   (clock),
    .wr_en   (sram_wr_en),
    .wr_addr (sram_wr_addr),
    .wr_data (sram_wr_data),
    .rd_en   (rd_fire),
    .rd_addr (tagarray_rd_idx),
    .rd_data (sram_rd_data)
  );

  // Response register: valid pulse, valids, bypass mask and last-presented tags.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      rd_valids_q  <= '0;
      byp_mask_q   <= '0;
      hold_tags_q  <= '0;
    end else begin
      resp_valid_q <= rd_fire;
      hold_tags_q  <= tagarray_rd_tags;
      if (rd_fire) begin
        rd_valids_q <= rd_valids_next;
        byp_mask_q  <= byp_mask_d;
      end
    end
  end

  // Bypass tag only matters when byp_mask_q is non-zero, so no reset is needed.
  always_ff @(posedge clock) begin
    if (rd_fire) begin
      byp_tag_q <= tagarray_wr_tag;
    end
  end

  // Overlay same-cycle written ways on the array read data.
  always_comb begin
    merged_tags = sram_rd_data;
    for (int w = 0; w < WAYS; w++) begin
      if (byp_mask_q[w]) begin
        merged_tags[w*TAG_WIDTH +: TAG_WIDTH] = byp_tag_q;
      end
    end
  end

  assign tagarray_rd_resp_valid = resp_valid_q;
  assign tagarray_rd_tags       = resp_valid_q ? merged_tags : hold_tags_q;
  assign tagarray_rd_valids     = rd_valids_q;

endmodule
